// File: rtl/rom_dl_writer_if.sv
// Host download port plus program ROM / colour PROM write ports of rom_dl_writer.
// master: the download host side; slave: the writer itself.
interface rom_dl_writer_if #(
    parameter int unsigned ROM_AW  = 11,
    parameter int unsigned PROM_AW = 8
);
    logic               dl_start;
    logic               dl_end;
    logic               dl_valid;
    logic [7:0]         dl_data;
    logic               dl_ready;
    logic [ROM_AW-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic               rom_we;
    logic [PROM_AW-1:0] prom_addr;
    logic [3:0]         prom_data;
    logic               prom_we;
    logic               dl_busy;
    logic               dl_done;
    logic               dl_err;
    logic               cpu_hold;

    modport master (
        output dl_start, dl_end, dl_valid, dl_data,
        input  dl_ready, rom_addr, rom_data, rom_we, prom_addr, prom_data, prom_we,
        input  dl_busy, dl_done, dl_err, cpu_hold
    );

    modport slave (
        input  dl_start, dl_end, dl_valid, dl_data,
        output dl_ready, rom_addr, rom_data, rom_we, prom_addr, prom_data, prom_we,
        output dl_busy, dl_done, dl_err, cpu_hold
    );
endinterface

// File: rtl/rom_dl_writer.sv
// Streams host download bytes into the program ROM then the colour PROM, holding the
// game logic in reset until both images have been written.
module rom_dl_writer #(
    parameter int unsigned ROM_BYTES  = 2048,
    parameter int unsigned PROM_BYTES = 256,
    parameter int unsigned ROM_AW     = 11,
    parameter int unsigned PROM_AW    = 8
) (
    input logic            clk,
    input logic            n_reset,
    rom_dl_writer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StRom, StProm, StDone, StErr} state_e;

    state_e             state_q, state_d;
    logic [ROM_AW-1:0]  count_q, count_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [7:0]         rom_data_q, rom_data_d;
    logic               rom_we_q, rom_we_d;
    logic [PROM_AW-1:0] prom_addr_q, prom_addr_d;
    logic [3:0]         prom_data_q, prom_data_d;
    logic               prom_we_q, prom_we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;
    logic               loading;
    logic               accept;

    assign loading = (state_q == StRom) || (state_q == StProm);
    // A byte offered alongside dl_start belongs to the aborted stream and is dropped.
    assign accept  = bus.dl_valid && loading && !bus.dl_start;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            rom_we_q    <= 1'b0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
            prom_we_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            rom_we_q    <= rom_we_d;
            prom_addr_q <= prom_addr_d;
            prom_data_q <= prom_data_d;
            prom_we_q   <= prom_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        rom_we_d    = 1'b0;
        prom_addr_d = prom_addr_q;
        prom_data_d = prom_data_q;
        prom_we_d   = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        hold_d      = hold_q;

        if (bus.dl_start) begin
            state_d = StRom;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end else begin
            unique case (state_q)
                StRom: begin
                    if (accept) begin
                        rom_addr_d = count_q;
                        rom_data_d = bus.dl_data;
                        rom_we_d   = 1'b1;
                        if (count_q == ROM_AW'(ROM_BYTES - 1)) begin
                            count_d = '0;
                            state_d = StProm;
                        end else begin
                            count_d = count_q + ROM_AW'(1);
                        end
                    end
                    if (bus.dl_end) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
                StProm: begin
                    if (accept) begin
                        prom_addr_d = count_q[PROM_AW-1:0];
                        prom_data_d = bus.dl_data[3:0];
                        prom_we_d   = 1'b1;
                        count_d     = count_q + ROM_AW'(1);
                        if (bus.dl_data[7:4] != 4'h0) begin
                            err_d = 1'b1;
                        end
                    end
                    // Completion takes priority over a coincident dl_end.
                    if (accept && (count_q == ROM_AW'(PROM_BYTES - 1))) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (bus.dl_end) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dl_ready  = loading && !bus.dl_start;
    assign bus.dl_busy   = loading;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_data  = rom_data_q;
    assign bus.rom_we    = rom_we_q;
    assign bus.prom_addr = prom_addr_q;
    assign bus.prom_data = prom_data_q;
    assign bus.prom_we   = prom_we_q;
    assign bus.dl_done   = done_q;
    assign bus.dl_err    = err_q;
    assign bus.cpu_hold  = hold_q;
endmodule

// File: tb/tb_rom_dl_writer.sv
// Bench for rom_dl_writer: a byte-index reference model queues the expected memory writes
// and a negedge monitor pops and compares them as strobes appear.
module tb_rom_dl_writer;
    localparam int ROM_N  = 2048;
    localparam int PROM_N = 256;
    localparam int TOTAL  = ROM_N + PROM_N;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    rom_dl_writer_if #(.ROM_AW(11), .PROM_AW(8)) bus ();

    rom_dl_writer #(
        .ROM_BYTES (ROM_N),
        .PROM_BYTES(PROM_N),
        .ROM_AW    (11),
        .PROM_AW   (8)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    typedef struct {
        bit prom;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: position in the concatenated ROM+PROM stream plus sticky flags.
    bit  m_loading = 0;
    bit  m_done = 0;
    bit  m_err = 0;
    bit  m_hold = 1;
    int  m_idx = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin : monitor
        wr_t e;
        if (n_reset && (bus.rom_we || bus.prom_we)) begin
            check("strobe_exclusive", int'(bus.rom_we && bus.prom_we), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("write_target_prom", int'(bus.prom_we), int'(e.prom));
                if (e.prom) begin
                    check("prom_addr", int'(bus.prom_addr), e.addr);
                    check("prom_data", int'(bus.prom_data), e.data);
                end else begin
                    check("rom_addr", int'(bus.rom_addr), e.addr);
                    check("rom_data", int'(bus.rom_data), e.data);
                end
            end
        end
    end

    task automatic drive(input bit s, input bit e, input bit v, input logic [7:0] d);
        bit  rdy;
        wr_t w;
        bus.dl_start = s;
        bus.dl_end   = e;
        bus.dl_valid = v;
        bus.dl_data  = d;
        rdy = m_loading && !s;
        #1;
        check("dl_ready", int'(bus.dl_ready), int'(rdy));
        if (s) begin
            m_idx = 0; m_loading = 1; m_done = 0; m_err = 0; m_hold = 1;
        end else if (m_loading) begin
            if (v) begin
                w.prom = (m_idx >= ROM_N);
                w.addr = w.prom ? m_idx - ROM_N : m_idx;
                w.data = w.prom ? int'(d[3:0]) : int'(d);
                exp_q.push_back(w);
                if (w.prom && d[7:4] != 4'h0) m_err = 1;
                m_idx++;
            end
            if (m_idx == TOTAL) begin
                m_loading = 0; m_done = 1; m_hold = 0;
            end else if (e) begin
                m_loading = 0; m_err = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'($urandom));
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random valid and random data.
    task automatic stream(input int target, input int mode, input bit end_last, input int bad);
        int         budget = 20000;
        bit         v;
        logic [7:0] d;
        while (m_loading && m_idx < target && budget > 0) begin
            if (mode == 0) v = 1;
            else if (mode == 1) v = budget[0];
            else v = 1'($urandom_range(0, 1));
            if (m_idx < ROM_N) d = (mode == 2) ? 8'($urandom) : 8'(m_idx);
            else if (m_idx - ROM_N == bad) d = 8'h3A;
            else d = (mode == 2) ? {4'h0, 4'($urandom)} : {4'h0, 4'(m_idx)};
            if (!v) d = 8'($urandom);
            drive(0, end_last && v && (m_idx == TOTAL - 1), v, d);
            budget--;
        end
        if (m_loading && m_idx < target) check("stream_timeout", m_idx, target);
    endtask

    task automatic check_status(string tag);
        check({tag, "_done"}, int'(bus.dl_done), int'(m_done));
        check({tag, "_err"}, int'(bus.dl_err), int'(m_err));
        check({tag, "_hold"}, int'(bus.cpu_hold), int'(m_hold));
        check({tag, "_busy"}, int'(bus.dl_busy), int'(m_loading));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
        check({tag, "_rom_data"}, int'(bus.rom_data), 0);
        check({tag, "_rom_we"}, int'(bus.rom_we), 0);
        check({tag, "_prom_addr"}, int'(bus.prom_addr), 0);
        check({tag, "_prom_data"}, int'(bus.prom_data), 0);
        check({tag, "_prom_we"}, int'(bus.prom_we), 0);
        check({tag, "_ready"}, int'(bus.dl_ready), 0);
        check({tag, "_done"}, int'(bus.dl_done), 0);
        check({tag, "_err"}, int'(bus.dl_err), 0);
        check({tag, "_busy"}, int'(bus.dl_busy), 0);
        check({tag, "_hold"}, int'(bus.cpu_hold), 1);
    endtask

    initial begin
        bus.dl_start = 0;
        bus.dl_end   = 0;
        bus.dl_valid = 0;
        bus.dl_data  = 8'h00;
        #12;
        check_reset_outputs("reset");
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        check_status("idle");

        // Full stream back-to-back, dl_end coincident with the final PROM byte.
        drive(1, 0, 0, 8'h00);
        stream(TOTAL, 0, 1, -1);
        idle(3);
        check_status("t1");
        check("t1_done_abs", int'(bus.dl_done), 1);
        check("t1_hold_abs", int'(bus.cpu_hold), 0);

        // Same stream, valid every other cycle.
        drive(1, 0, 0, 8'h00);
        stream(TOTAL, 1, 0, -1);
        idle(3);
        check_status("t2");

        // Early dl_end: error state, no further writes.
        drive(1, 0, 0, 8'h00);
        stream(100, 0, 0, -1);
        drive(0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'($urandom));
        check_status("t3");
        check("t3_err_abs", int'(bus.dl_err), 1);
        check("t3_hold_abs", int'(bus.cpu_hold), 1);

        // Restart with a byte offered on the dl_start cycle.
        drive(1, 0, 0, 8'h00);
        stream(500, 0, 0, -1);
        drive(1, 0, 1, 8'h55);
        stream(TOTAL, 2, 0, -1);
        idle(3);
        check_status("t4");

        // PROM byte 0x3A at index 7.
        drive(1, 0, 0, 8'h00);
        stream(TOTAL, 2, 0, 7);
        idle(3);
        check_status("t5");
        check("t5_err_abs", int'(bus.dl_err), 1);
        check("t5_done_abs", int'(bus.dl_done), 1);

        // Asynchronous reset in the PROM phase, then a clean reload.
        drive(1, 0, 0, 8'h00);
        stream(ROM_N + 50, 0, 0, -1);
        #3;
        n_reset = 1'b0;
        bus.dl_valid = 0;
        exp_q.delete();
        m_loading = 0; m_done = 0; m_err = 0; m_hold = 1; m_idx = 0;
        #1;
        check_reset_outputs("t6_reset");
        #10;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 8'h00);
        stream(TOTAL, 0, 0, -1);
        idle(3);
        check_status("t6");

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
